imem_loader: RTL and testbench

Program loader that fills the CPU's instruction memory from a byte stream before execution starts. It is the write-side counterpart to the CPU's instruction fetch. It receives a framed program over a valid/ready byte interface, assembles big-endian 16-bit instruction words, and writes them to the instruction-memory write port at even byte addresses (PC steps by 2). It holds the CPU in reset until a complete, checksum-verified program has been loaded.

---
 rtl/imem_loader.sv | 163 ++++++++++++++++
 tb/tb_imem_loader.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
`default_nettype none
// ============================================================================
//  Module   : imem_loader
//  Brief    : Loads a framed, checksum-protected program from a byte stream
//             into instruction memory (big-endian 16-bit words, even byte
//             addresses) and holds the CPU in reset until the load succeeds.
//  Revision : 1.0 - initial release
// ============================================================================
module imem_loader #(
   parameter int DEPTH = 256,
   parameter int CNT_W = 9
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             in_valid,
   input  logic [7:0]       in_data,
   output logic             in_ready,
   output logic             wr_en,
   output logic [15:0]      wr_addr,
   output logic [15:0]      wr_data,
   output logic             cpu_reset,
   output logic             done,
   output logic             error,
   output logic [CNT_W-1:0] word_count
);

   localparam logic [2:0] S_LEN_HI  = 3'd0;
   localparam logic [2:0] S_LEN_LO  = 3'd1;
   localparam logic [2:0] S_DATA_HI = 3'd2;
   localparam logic [2:0] S_DATA_LO = 3'd3;
   localparam logic [2:0] S_CHECK   = 3'd4;
   localparam logic [2:0] S_DONE    = 3'd5;
   localparam logic [2:0] S_ERROR   = 3'd6;

   localparam logic [15:0]      DEPTH_W = 16'(DEPTH);
   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   logic [2:0]       state_q,      state_d;
   logic [15:0]      length_q,     length_d;
   logic [7:0]       hold_q,       hold_d;
   logic [7:0]       checksum_q,   checksum_d;
   logic [CNT_W-1:0] word_count_q, word_count_d;
   logic             wr_en_q,      wr_en_d;
   logic [15:0]      wr_addr_q,    wr_addr_d;
   logic [15:0]      wr_data_q,    wr_data_d;

   logic             w_xfer;
   logic [15:0]      w_len;
   logic [CNT_W-1:0] w_cnt_inc;

   // Handshake is accepted in every receiving state; terminal states stall the stream.
   always_comb begin
      in_ready = 1'b0;
      case (state_q)
         S_LEN_HI, S_LEN_LO, S_DATA_HI, S_DATA_LO, S_CHECK: in_ready = 1'b1;
         default:                                           in_ready = 1'b0;
      endcase
   end

   assign w_xfer    = in_valid & in_ready;
   assign w_len     = {length_q[15:8], in_data};
   assign w_cnt_inc = word_count_q + CNT_ONE;

   // Next-state and datapath update; nothing changes without a byte transfer
   // except the write strobe dropping and the start re-arm from a terminal state.
   always_comb begin
      state_d      = state_q;
      length_d     = length_q;
      hold_d       = hold_q;
      checksum_d   = checksum_q;
      word_count_d = word_count_q;
      wr_en_d      = 1'b0;
      wr_addr_d    = wr_addr_q;
      wr_data_d    = wr_data_q;
      case (state_q)
         S_LEN_HI: begin
            if (w_xfer) begin
               length_d[15:8] = in_data;
               state_d        = S_LEN_LO;
            end
         end
         S_LEN_LO: begin
            if (w_xfer) begin
               length_d = w_len;
               if (w_len > DEPTH_W) begin
                  state_d = S_ERROR;
               end else if (w_len == 16'd0) begin
                  state_d = S_CHECK;
               end else begin
                  state_d = S_DATA_HI;
               end
            end
         end
         S_DATA_HI: begin
            if (w_xfer) begin
               hold_d     = in_data;
               checksum_d = checksum_q ^ in_data;
               state_d    = S_DATA_LO;
            end
         end
         S_DATA_LO: begin
            if (w_xfer) begin
               checksum_d   = checksum_q ^ in_data;
               wr_en_d      = 1'b1;
               wr_data_d    = {hold_q, in_data};
               wr_addr_d    = 16'(word_count_q) << 1;
               word_count_d = w_cnt_inc;
               state_d      = (16'(w_cnt_inc) == length_q) ? S_CHECK : S_DATA_HI;
            end
         end
         S_CHECK: begin
            if (w_xfer) begin
               state_d = (in_data == checksum_q) ? S_DONE : S_ERROR;
            end
         end
         S_DONE, S_ERROR: begin
            if (start) begin
               word_count_d = '0;
               checksum_d   = 8'h00;
               state_d      = S_LEN_HI;
            end
         end
         default: begin
            state_d = S_LEN_HI;
         end
      endcase
   end

   // State registers; reset abandons any load in progress immediately.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= S_LEN_HI;
         length_q     <= 16'h0000;
         hold_q       <= 8'h00;
         checksum_q   <= 8'h00;
         word_count_q <= '0;
         wr_en_q      <= 1'b0;
         wr_addr_q    <= 16'h0000;
         wr_data_q    <= 16'h0000;
      end else begin
         state_q      <= state_d;
         length_q     <= length_d;
         hold_q       <= hold_d;
         checksum_q   <= checksum_d;
         word_count_q <= word_count_d;
         wr_en_q      <= wr_en_d;
         wr_addr_q    <= wr_addr_d;
         wr_data_q    <= wr_data_d;
      end
   end

   assign wr_en      = wr_en_q;
   assign wr_addr    = wr_addr_q;
   assign wr_data    = wr_data_q;
   assign word_count = word_count_q;
   assign done       = (state_q == S_DONE);
   assign error      = (state_q == S_ERROR);
   // The CPU only leaves reset after a verified load; partial programs never run.
   assign cpu_reset  = (state_q != S_DONE);

endmodule
`default_nettype wire

// File: tb/tb_imem_loader.sv
`default_nettype none
// ============================================================================
//  Module   : tb_imem_loader
//  Brief    : Self-checking bench for imem_loader against a frame-level model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_imem_loader;

   localparam int DEPTH = 256;
   localparam int CNT_W = 9;

   logic             clk = 1'b0;
   logic             reset;
   logic             start;
   logic             in_valid;
   logic [7:0]       in_data;
   logic             in_ready;
   logic             wr_en;
   logic [15:0]      wr_addr;
   logic [15:0]      wr_data;
   logic             cpu_reset;
   logic             done;
   logic             error;
   logic [CNT_W-1:0] word_count;

   imem_loader #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .in_valid   (in_valid),
      .in_data    (in_data),
      .in_ready   (in_ready),
      .wr_en      (wr_en),
      .wr_addr    (wr_addr),
      .wr_data    (wr_data),
      .cpu_reset  (cpu_reset),
      .done       (done),
      .error      (error),
      .word_count (word_count)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;
   int n_writes = 0;
   bit checking = 1'b0;

   // Frame currently being sent and its frame-level expectations.
   logic [7:0]  frame[$];
   int          m_n;
   int          m_total;   // bytes the loader is expected to accept
   bit          m_good;
   int          m_acc;     // bytes accepted so far
   int          m_wc;
   logic        m_wr_en;
   logic [15:0] m_addr;
   logic [15:0] m_data;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
   endtask

   function automatic logic [7:0] xsum(input int n);
      logic [7:0] x = 8'h00;
      for (int i = 0; i < 2 * n; i++) x ^= frame[2 + i];
      return x;
   endfunction

   // Random frame of n words; a corrupted checksum when bad is set.
   task automatic build(input int n, input bit bad);
      logic [7:0] ck;
      frame.delete();
      frame.push_back(8'(n >> 8));
      frame.push_back(8'(n & 255));
      if (n <= DEPTH) begin
         for (int i = 0; i < 2 * n; i++) frame.push_back(8'($urandom));
         ck = xsum(n);
         if (bad) ck ^= 8'($urandom_range(1, 255));
         frame.push_back(ck);
      end
   endtask

   // Load frame-level expectations for a fresh load of the current frame.
   task automatic arm();
      m_n     = {frame[0], frame[1]};
      m_total = (m_n > DEPTH) ? 2 : 2 * m_n + 3;
      m_good  = (m_n <= DEPTH) && (frame[2 + 2 * m_n] == xsum(m_n));
      m_acc   = 0;
      m_wc    = 0;
      m_wr_en = 1'b0;
   endtask

   task automatic pulse_start();
      in_valid = 1'b0;
      start    = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      arm();
   endtask

   // mode 0: valid always high, 1: valid toggles, 2: random valid and stray start pulses.
   // stop_wc > 0 stops as soon as that many words have been written.
   task automatic run_frame(input int mode, input int stop_wc);
      int post = 0;
      int cyc  = 0;
      int idx;
      int k;
      bit xfer;
      while (1) begin
         if (stop_wc > 0 && m_wc >= stop_wc) break;
         if (m_acc >= m_total && post >= 3) break;
         case (mode)
            0:       in_valid = 1'b1;
            1:       in_valid = (cyc % 2 == 0);
            default: in_valid = ($urandom_range(0, 2) != 0);
         endcase
         in_data = (m_acc < frame.size()) ? frame[m_acc] : 8'($urandom);
         start   = (mode == 2 && m_acc < m_total && $urandom_range(0, 7) == 0);
         @(posedge clk);
         xfer = in_valid && (m_acc < m_total);
         #1;
         m_wr_en = 1'b0;
         if (xfer) begin
            idx = m_acc;
            m_acc++;
            if (idx >= 3 && idx <= 2 * m_n + 1 && (idx % 2) == 1) begin
               k       = (idx - 3) / 2;
               m_wr_en = 1'b1;
               m_addr  = 16'(2 * k);
               m_data  = {frame[idx - 1], frame[idx]};
               m_wc    = k + 1;
            end
         end
         if (m_acc >= m_total) post++;
         cyc++;
         if (cyc > 4 * frame.size() + 50) begin
            n_checks++;
            $display("FAIL frame_timeout: accepted %0d bytes, required %0d", m_acc, m_total);
            break;
         end
      end
      in_valid = 1'b0;
      start    = 1'b0;
   endtask

   // Every cycle: DUT outputs against the frame-level expectations.
   always @(negedge clk) begin
      if (checking) begin
         chk("in_ready",   32'(in_ready),   32'(m_acc < m_total));
         chk("wr_en",      32'(wr_en),      32'(m_wr_en));
         chk("wr_addr",    32'(wr_addr),    32'(m_addr));
         chk("wr_data",    32'(wr_data),    32'(m_data));
         chk("word_count", 32'(word_count), 32'(m_wc));
         chk("done",       32'(done),       32'(m_acc >= m_total && m_good));
         chk("error",      32'(error),      32'(m_acc >= m_total && !m_good));
         chk("cpu_reset",  32'(cpu_reset),  32'(!(m_acc >= m_total && m_good)));
         if (wr_en === 1'b1) n_writes++;
      end
   end

   task automatic chk_reset_values(input string tag);
      chk({tag, "_in_ready"},  32'(in_ready),   32'd1);
      chk({tag, "_wr_en"},     32'(wr_en),      32'd0);
      chk({tag, "_wr_addr"},   32'(wr_addr),    32'd0);
      chk({tag, "_wr_data"},   32'(wr_data),    32'd0);
      chk({tag, "_cpu_reset"}, 32'(cpu_reset),  32'd1);
      chk({tag, "_done"},      32'(done),       32'd0);
      chk({tag, "_error"},     32'(error),      32'd0);
      chk({tag, "_wcount"},    32'(word_count), 32'd0);
   endtask

   int w0;

   initial begin
      reset    = 1'b1;
      start    = 1'b0;
      in_valid = 1'b0;
      in_data  = 8'h00;
      m_n = 0; m_total = 1; m_good = 1'b0; m_acc = 0; m_wc = 0;
      m_wr_en = 1'b0; m_addr = 16'h0000; m_data = 16'h0000;
      #2;
      chk_reset_values("por");
      @(posedge clk);
      @(posedge clk);
      #1;
      reset = 1'b0;

      // Reference frame, valid held high.
      frame = {8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h40};
      chk("model_xsum", 32'(xsum(2)), 32'h40);
      arm();
      checking = 1'b1;
      w0 = n_writes;
      run_frame(0, 0);
      chk("f1_done",      32'(done),          32'd1);
      chk("f1_cpu_reset", 32'(cpu_reset),     32'd0);
      chk("f1_wcount",    32'(word_count),    32'd2);
      chk("f1_last_addr", 32'(wr_addr),       32'h0002);
      chk("f1_last_data", 32'(wr_data),       32'hABCD);
      chk("f1_writes",    32'(n_writes - w0), 32'd2);

      // Bad checksum: writes still happen, load ends in error.
      frame[6] = 8'h41;
      pulse_start();
      w0 = n_writes;
      run_frame(0, 0);
      chk("f2_error",    32'(error),         32'd1);
      chk("f2_done",     32'(done),          32'd0);
      chk("f2_cpu_rst",  32'(cpu_reset),     32'd1);
      chk("f2_in_ready", 32'(in_ready),      32'd0);
      chk("f2_writes",   32'(n_writes - w0), 32'd2);

      frame[6] = 8'h40;
      pulse_start();
      run_frame(0, 0);
      chk("f3_done", 32'(done), 32'd1);

      // Empty program, good and bad checksum.
      frame = {8'h00, 8'h00, 8'h00};
      pulse_start();
      w0 = n_writes;
      run_frame(0, 0);
      chk("f4_done",   32'(done),          32'd1);
      chk("f4_writes", 32'(n_writes - w0), 32'd0);
      frame = {8'h00, 8'h00, 8'h01};
      pulse_start();
      run_frame(0, 0);
      chk("f5_error", 32'(error), 32'd1);

      // Oversize length: rejected straight after the length bytes.
      frame = {8'h01, 8'h01};
      pulse_start();
      w0 = n_writes;
      run_frame(0, 0);
      chk("f6_error",    32'(error),         32'd1);
      chk("f6_writes",   32'(n_writes - w0), 32'd0);
      chk("f6_in_ready", 32'(in_ready),      32'd0);

      // Reference frame with valid toggling every cycle.
      frame = {8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h40};
      pulse_start();
      run_frame(1, 0);
      chk("f7_done",   32'(done),       32'd1);
      chk("f7_wcount", 32'(word_count), 32'd2);

      // Asynchronous reset after the first word, then a full reload.
      build(3, 1'b0);
      pulse_start();
      run_frame(0, 1);
      #2;
      checking = 1'b0;
      reset    = 1'b1;
      #1;
      chk_reset_values("arst");
      @(posedge clk);
      #1;
      reset  = 1'b0;
      m_addr = 16'h0000;
      m_data = 16'h0000;
      arm();
      checking = 1'b1;
      run_frame(0, 0);
      chk("f8_done", 32'(done), 32'd1);

      // Random frames with random valid gaps and ignored start pulses.
      repeat (8) begin
         build($urandom_range(1, 6), ($urandom_range(0, 3) == 0));
         pulse_start();
         run_frame(2, 0);
      end

      // Full-capacity program.
      build(DEPTH, 1'b0);
      pulse_start();
      run_frame(0, 0);
      chk("full_done",   32'(done),       32'd1);
      chk("full_wcount", 32'(word_count), 32'(DEPTH));
      chk("full_addr",   32'(wr_addr),    32'h01FE);

      checking = 1'b0;
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
